// File: rtl/pc_stack_unit_pkg.sv
// Shared definitions for the PC/stack unit: widths, reset vector, fetch/execute
// phase encodings, stack commands and the Q4 decode helpers.
package pc_stack_unit_pkg;

  localparam int          PC_WIDTH_DEF     = 11;
  localparam logic [10:0] RESET_VECTOR_DEF = 11'h7FF;
  localparam int          FE_STATE_BITS    = 2;
  localparam int          EX_STATE_BITS    = 4;
  localparam logic [1:0]  STK_DEPTH        = 2'd2;

  typedef enum logic [FE_STATE_BITS-1:0] {
    FE_Q1 = 2'd0,
    FE_Q2 = 2'd1,
    FE_Q3 = 2'd2,
    FE_Q4 = 2'd3
  } fe_state_e;

  typedef enum logic [EX_STATE_BITS-1:0] {
    EX_Q1       = 4'd0,
    EX_Q2       = 4'd1,
    EX_Q3       = 4'd2,
    EX_Q4_CLRF  = 4'd3,
    EX_Q4_MOVWF = 4'd4,
    EX_Q4_BXF   = 4'd5,
    EX_Q4_FSZ   = 4'd6,
    EX_Q4_BTFSX = 4'd7,
    EX_Q4_GOTO  = 4'd8,
    EX_Q4_CALL  = 4'd9,
    EX_Q4_RETLW = 4'd10,
    EX_Q4_ELSE  = 4'd11,
    EX_Q4_NOP   = 4'd12
  } ex_state_e;

  typedef enum logic [1:0] {
    STK_NOP  = 2'b00,
    STK_PUSH = 2'b01,
    STK_POP  = 2'b10
  } stk_cmd_e;

  typedef enum logic [2:0] {
    PC_SRC_HOLD = 3'd0,
    PC_SRC_INC  = 3'd1,
    PC_SRC_GOTO = 3'd2,
    PC_SRC_CALL = 3'd3,
    PC_SRC_RET  = 3'd4,
    PC_SRC_PCL  = 3'd5,
    PC_SRC_SKIP = 3'd6
  } pc_src_e;

  // Execute states in which an ALU write to PCL redirects the program counter.
  function automatic logic ex_allows_pcl(input ex_state_e s);
    logic ok;
    case (s)
      EX_Q4_ELSE, EX_Q4_MOVWF, EX_Q4_CLRF, EX_Q4_BXF: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic ex_allows_skip(input ex_state_e s);
    logic ok;
    case (s)
      EX_Q4_FSZ, EX_Q4_BTFSX: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Control-unit to PC/stack unit bundle; the control unit is the master, the
// PC/stack unit the slave.
interface pc_stack_unit_if
  import pc_stack_unit_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) ();

  fe_state_e           fetch_state;
  ex_state_e           execute_state;
  stk_cmd_e            stack_command;
  logic [11:0]         inst_in;
  logic [1:0]          pa;
  logic                pcl_write;
  logic [7:0]          alu_result;
  logic                skip_req;
  logic [PC_WIDTH-1:0] pc_out;
  logic                flush;
  logic                stk_ovf;
  logic                stk_unf;

  modport master (
    output fetch_state, execute_state, stack_command, inst_in, pa,
           pcl_write, alu_result, skip_req,
    input  pc_out, flush, stk_ovf, stk_unf
  );

  modport slave (
    input  fetch_state, execute_state, stack_command, inst_in, pa,
           pcl_write, alu_result, skip_req,
    output pc_out, flush, stk_ovf, stk_unf
  );

endinterface

// File: rtl/pc_stack_unit_pic_stack.sv
// Two-entry shift-register return stack with saturating occupancy counter and
// sticky overflow/underflow flags.
module pc_stack_unit_pic_stack
  import pc_stack_unit_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_ovf,
  output logic             o_unf
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [1:0]       r_occ;
  logic             r_ovf;
  logic             r_unf;

  // Stack entries, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_occ <= 2'd0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (i_push) begin
      r_s2 <= r_s1;
      r_s1 <= i_push_data;
      // A full stack drops the oldest return address and stays full.
      if (r_occ == STK_DEPTH) begin
        r_ovf <= 1'b1;
      end else begin
        r_occ <= r_occ + 2'd1;
      end
    end else if (i_pop) begin
      // S2 is left in place, so repeated pops keep returning the deepest entry.
      r_s1 <= r_s2;
      if (r_occ == 2'd0) begin
        r_unf <= 1'b1;
      end else begin
        r_occ <= r_occ - 2'd1;
      end
    end else begin
      r_s1  <= r_s1;
      r_s2  <= r_s2;
      r_occ <= r_occ;
    end
  end

  assign o_top = r_s1;
  assign o_ovf = r_ovf;
  assign o_unf = r_unf;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with Q1 increment, Q4 control-flow redirects (GOTO, CALL,
// RETLW, PCL write, skip) and a registered prefetch-flush pulse.
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF)
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_stack_unit_if.slave bus
);

  logic [PC_WIDTH-1:0] r_pc;
  logic                r_flush;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [PC_WIDTH-1:0] w_stack_top;
  logic                w_flush_next;
  logic                w_push;
  logic                w_pop;
  logic                w_ovf;
  logic                w_unf;
  pc_src_e             w_src;
  logic                w_unused;

  // Select the PC source; the if-chain order encodes the Q4 priority.
  always_comb begin
    w_src  = PC_SRC_HOLD;
    w_push = 1'b0;
    w_pop  = 1'b0;
    if (bus.fetch_state == FE_Q1) begin
      w_src = PC_SRC_INC;
    end else if (bus.execute_state == EX_Q4_GOTO) begin
      w_src = PC_SRC_GOTO;
    end else if ((bus.execute_state == EX_Q4_CALL) && (bus.stack_command == STK_PUSH)) begin
      w_src  = PC_SRC_CALL;
      w_push = 1'b1;
    end else if ((bus.execute_state == EX_Q4_RETLW) && (bus.stack_command == STK_POP)) begin
      w_src = PC_SRC_RET;
      w_pop = 1'b1;
    end else if (bus.pcl_write && ex_allows_pcl(bus.execute_state)) begin
      w_src = PC_SRC_PCL;
    end else if (bus.skip_req && ex_allows_skip(bus.execute_state)) begin
      w_src = PC_SRC_SKIP;
    end else begin
      w_src = PC_SRC_HOLD;
    end
  end

  // Next PC value and whether the prefetched word must be discarded.
  always_comb begin
    w_pc_next    = r_pc;
    w_flush_next = 1'b0;
    case (w_src)
      PC_SRC_INC: begin
        w_pc_next = r_pc + PC_WIDTH'(1);
      end
      PC_SRC_GOTO: begin
        w_pc_next    = PC_WIDTH'({bus.pa, bus.inst_in[8:0]});
        w_flush_next = 1'b1;
      end
      PC_SRC_CALL: begin
        w_pc_next    = PC_WIDTH'({bus.pa, 1'b0, bus.inst_in[7:0]});
        w_flush_next = 1'b1;
      end
      PC_SRC_RET: begin
        w_pc_next    = w_stack_top;
        w_flush_next = 1'b1;
      end
      PC_SRC_PCL: begin
        w_pc_next    = PC_WIDTH'({bus.pa, 1'b0, bus.alu_result});
        w_flush_next = 1'b1;
      end
      PC_SRC_SKIP: begin
        w_pc_next    = r_pc;
        w_flush_next = 1'b1;
      end
      default: begin
        w_pc_next    = r_pc;
        w_flush_next = 1'b0;
      end
    endcase
  end

  // Program counter and flush pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_VECTOR;
      r_flush <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_flush <= w_flush_next;
    end
  end

  pc_stack_unit_pic_stack #(
    .WIDTH (PC_WIDTH)
  ) u_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (r_pc),
    .o_top       (w_stack_top),
    .o_ovf       (w_ovf),
    .o_unf       (w_unf)
  );

  assign bus.pc_out  = r_pc;
  assign bus.flush   = r_flush;
  assign bus.stk_ovf = w_ovf;
  assign bus.stk_unf = w_unf;

  // Opcode bits above the 9-bit GOTO literal carry no address information.
  assign w_unused = ^bus.inst_in[11:9];

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: reset, free-run, GOTO/CALL/RETLW, stack
// overflow/underflow, PCL write priority, skip and reset during Q4.
module tb_pc_stack_unit;
  import pc_stack_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   flush_seen;

  always #5 clk = ~clk;

  pc_stack_unit_if bus ();

  pc_stack_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle(input fe_state_e fe);
    bus.fetch_state   = fe;
    bus.execute_state = EX_Q1;
    bus.stack_command = STK_NOP;
    bus.inst_in       = 12'h000;
    bus.pa            = 2'b00;
    bus.pcl_write     = 1'b0;
    bus.alu_result    = 8'h00;
    bus.skip_req      = 1'b0;
  endtask

  task automatic instr(input ex_state_e ex, input stk_cmd_e cmd, input logic [11:0] inst,
                       input logic [1:0] pa, input logic pclw, input logic [7:0] alu,
                       input logic skip);
    set_idle(FE_Q1); tick();
    set_idle(FE_Q2); tick();
    set_idle(FE_Q3); tick();
    bus.fetch_state   = FE_Q4;
    bus.execute_state = ex;
    bus.stack_command = cmd;
    bus.inst_in       = inst;
    bus.pa            = pa;
    bus.pcl_write     = pclw;
    bus.alu_result    = alu;
    bus.skip_req      = skip;
    tick();
    set_idle(FE_Q1);
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle(FE_Q2);
    #12;
    chk("rst_pc",    32'(bus.pc_out),  32'h7FF);
    chk("rst_flush", 32'(bus.flush),   32'h0);
    chk("rst_ovf",   32'(bus.stk_ovf), 32'h0);
    chk("rst_unf",   32'(bus.stk_unf), 32'h0);
    rst_n = 1'b1;

    // Free run: four instruction cycles, wrap 7FF -> 000.
    flush_seen = 0;
    set_idle(FE_Q2); tick();
    chk("run_pc_init", 32'(bus.pc_out), 32'h7FF);
    for (int i = 0; i < 4; i++) begin
      set_idle(FE_Q1); tick();
      chk("run_pc", 32'(bus.pc_out), 32'(i));
      flush_seen += int'(bus.flush);
      set_idle(FE_Q2); tick(); flush_seen += int'(bus.flush);
      set_idle(FE_Q3); tick(); flush_seen += int'(bus.flush);
      set_idle(FE_Q4); tick(); flush_seen += int'(bus.flush);
    end
    chk("run_no_flush", 32'(flush_seen), 32'h0);

    // GOTO 0x1A5 with pa=01.
    instr(EX_Q4_GOTO, STK_NOP, 12'hA5 | 12'h100, 2'b01, 1'b0, 8'h00, 1'b0);
    chk("goto_pc",    32'(bus.pc_out), 32'h3A5);
    chk("goto_flush", 32'(bus.flush),  32'h1);
    set_idle(FE_Q2); tick();
    chk("goto_flush_end", 32'(bus.flush),  32'h0);
    chk("goto_pc_hold",   32'(bus.pc_out), 32'h3A5);

    // CALL 0x40 from PC 0x123, then RETLW.
    instr(EX_Q4_GOTO, STK_NOP, 12'h122, 2'b00, 1'b0, 8'h00, 1'b0);
    chk("pre_call_pc", 32'(bus.pc_out), 32'h122);
    instr(EX_Q4_CALL, STK_PUSH, 12'h040, 2'b00, 1'b0, 8'h00, 1'b0);
    chk("call_pc",    32'(bus.pc_out),       32'h040);
    chk("call_s1",    32'(dut.u_stack.r_s1),  32'h123);
    chk("call_occ",   32'(dut.u_stack.r_occ), 32'h1);
    chk("call_flush", 32'(bus.flush),        32'h1);
    instr(EX_Q4_RETLW, STK_POP, 12'h000, 2'b00, 1'b0, 8'h00, 1'b0);
    chk("ret_pc",    32'(bus.pc_out),       32'h123);
    chk("ret_occ",   32'(dut.u_stack.r_occ), 32'h0);
    chk("ret_unf",   32'(bus.stk_unf),      32'h0);
    chk("ret_flush", 32'(bus.flush),        32'h1);

    // Three nested calls from 0x010, 0x020, 0x030.
    instr(EX_Q4_GOTO, STK_NOP, 12'h00F, 2'b00, 1'b0, 8'h00, 1'b0);
    instr(EX_Q4_CALL, STK_PUSH, 12'h01F, 2'b00, 1'b0, 8'h00, 1'b0);
    chk("nest1_pc", 32'(bus.pc_out), 32'h01F);
    instr(EX_Q4_CALL, STK_PUSH, 12'h02F, 2'b00, 1'b0, 8'h00, 1'b0);
    chk("nest2_ovf", 32'(bus.stk_ovf),      32'h0);
    chk("nest2_occ", 32'(dut.u_stack.r_occ), 32'h2);
    instr(EX_Q4_CALL, STK_PUSH, 12'h07F, 2'b00, 1'b0, 8'h00, 1'b0);
    chk("nest3_pc",  32'(bus.pc_out),       32'h07F);
    chk("nest3_ovf", 32'(bus.stk_ovf),      32'h1);
    chk("nest3_occ", 32'(dut.u_stack.r_occ), 32'h2);
    instr(EX_Q4_RETLW, STK_POP, 12'h000, 2'b00, 1'b0, 8'h00, 1'b0);
    chk("pop1_pc",  32'(bus.pc_out),  32'h030);
    chk("pop1_unf", 32'(bus.stk_unf), 32'h0);
    instr(EX_Q4_RETLW, STK_POP, 12'h000, 2'b00, 1'b0, 8'h00, 1'b0);
    chk("pop2_pc",  32'(bus.pc_out),       32'h020);
    chk("pop2_occ", 32'(dut.u_stack.r_occ), 32'h0);
    chk("pop2_unf", 32'(bus.stk_unf),      32'h0);
    instr(EX_Q4_RETLW, STK_POP, 12'h000, 2'b00, 1'b0, 8'h00, 1'b0);
    chk("pop3_pc",  32'(bus.pc_out),  32'h020);
    chk("pop3_unf", 32'(bus.stk_unf), 32'h1);
    chk("pop3_ovf", 32'(bus.stk_ovf), 32'h1);

    // PCL write with simultaneous skip: load wins, single flush pulse.
    instr(EX_Q4_MOVWF, STK_NOP, 12'h000, 2'b10, 1'b1, 8'hFF, 1'b1);
    chk("pcl_pc",    32'(bus.pc_out), 32'h4FF);
    chk("pcl_flush", 32'(bus.flush),  32'h1);
    set_idle(FE_Q2); tick();
    chk("pcl_flush_end", 32'(bus.flush),  32'h0);
    chk("pcl_pc_hold",   32'(bus.pc_out), 32'h4FF);

    // skipReq outside FSZ/BTFSX and pclWrite outside its states are ignored.
    instr(EX_Q4_ELSE, STK_NOP, 12'h000, 2'b00, 1'b0, 8'h00, 1'b1);
    chk("skip_ign_pc",    32'(bus.pc_out), 32'h500);
    chk("skip_ign_flush", 32'(bus.flush),  32'h0);
    instr(EX_Q4_FSZ, STK_NOP, 12'h000, 2'b11, 1'b1, 8'h12, 1'b0);
    chk("pcl_ign_pc",    32'(bus.pc_out), 32'h501);
    chk("pcl_ign_flush", 32'(bus.flush),  32'h0);

    // Skip taken in BTFSx.
    instr(EX_Q4_BTFSX, STK_NOP, 12'h000, 2'b00, 1'b0, 8'h00, 1'b1);
    chk("skip_pc",    32'(bus.pc_out), 32'h502);
    chk("skip_flush", 32'(bus.flush),  32'h1);

    // Reset asserted during a DECFSZ Q4 with skip pending.
    set_idle(FE_Q1); tick();
    chk("fsz_q1_pc", 32'(bus.pc_out), 32'h503);
    set_idle(FE_Q2); tick();
    set_idle(FE_Q3); tick();
    bus.fetch_state   = FE_Q4;
    bus.execute_state = EX_Q4_FSZ;
    bus.skip_req      = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("q4rst_pc",    32'(bus.pc_out),  32'h7FF);
    chk("q4rst_flush", 32'(bus.flush),   32'h0);
    chk("q4rst_ovf",   32'(bus.stk_ovf), 32'h0);
    chk("q4rst_unf",   32'(bus.stk_unf), 32'h0);
    tick();
    chk("q4rst_edge_pc",    32'(bus.pc_out), 32'h7FF);
    chk("q4rst_edge_flush", 32'(bus.flush),  32'h0);
    set_idle(FE_Q2);
    #2;
    rst_n = 1'b1;
    tick();
    set_idle(FE_Q3); tick();
    set_idle(FE_Q4); tick();
    chk("rel_pc_hold", 32'(bus.pc_out), 32'h7FF);
    set_idle(FE_Q1); tick();
    chk("rel_pc_wrap", 32'(bus.pc_out), 32'h000);
    chk("rel_flush",   32'(bus.flush),  32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
